video_timing: RTL and testbench

VIDEO_TIMING -- requirements
Module: video_timing

---
 rtl/video_timing_pkg.sv | 34 +++
 rtl/video_timing_sync_window.sv | 30 +++
 rtl/video_timing.sv | 107 ++++++++++
 tb/tb_video_timing.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/video_timing_pkg.sv
// Raster geometry shared by the timing generator: counter widths and per-mode H/V constants.
package video_timing_pkg;

    localparam int unsigned HCntW = 11;
    localparam int unsigned VCntW = 10;

    localparam logic [HCntW-1:0] HOne = 1;
    localparam logic [VCntW-1:0] VOne = 1;

    typedef struct packed {
        logic [HCntW-1:0] h_active;
        logic [HCntW-1:0] h_fp;
        logic [HCntW-1:0] h_sync;
        logic [HCntW-1:0] h_total;
        logic [VCntW-1:0] v_active;
        logic [VCntW-1:0] v_fp;
        logic [VCntW-1:0] v_sync;
        logic [VCntW-1:0] v_total0;
        logic [VCntW-1:0] v_total1;
    } timing_t;

    localparam timing_t ProgTiming = '{
        h_active: 11'd640,  h_fp: 11'd16, h_sync: 11'd96,  h_total: 11'd800,
        v_active: 10'd480,  v_fp: 10'd10, v_sync: 10'd2,
        v_total0: 10'd525,  v_total1: 10'd525
    };

    localparam timing_t IlaceTiming = '{
        h_active: 11'd1280, h_fp: 11'd32, h_sync: 11'd128, h_total: 11'd1600,
        v_active: 10'd240,  v_fp: 10'd3,  v_sync: 10'd3,
        v_total0: 10'd262,  v_total1: 10'd263
    };

endpackage

// File: rtl/video_timing_sync_window.sv
// Registered active-low pulse while a counter lies in [start, start+len).
module sync_window #(
    parameter int unsigned Width = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [Width-1:0] cnt,
    input  logic [Width-1:0] start,
    input  logic [Width-1:0] len,
    output logic             sync_n
);

    logic [Width-1:0] offset;
    logic             in_win;

    always_comb begin
        offset = cnt - start;
        in_win = (cnt >= start) && (offset < len);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_n <= 1'b1;
        end else if (en) begin
            sync_n <= ~in_win;
        end
    end

endmodule

// File: rtl/video_timing.sv
// Raster timing generator: progressive VGA or interlaced fields, one raster position per tick
// (every second clk). All outputs are registered views of the position scanned on that tick.
module video_timing
    import video_timing_pkg::*;
#(
    parameter timing_t ProgCfg  = ProgTiming,
    parameter timing_t IlaceCfg = IlaceTiming
) (
    input  logic clk,
    input  logic rst_n,
    input  logic interlaced,
    output logic next_pixel,
    output logic next_line,
    output logic next_frame,
    output logic current_field,
    output logic hsync_n,
    output logic vsync_n,
    output logic blank
);

    timing_t          cfg;
    logic             tick_q, mode_q, mode_d, field_q, field_d;
    logic [HCntW-1:0] h_q, h_d, half_line, h_sync_start;
    logic [VCntW-1:0] v_q, v_d, v_total, v_sync_cnt, v_sync_start;
    logic             h_last, frame_end, active;
    logic             pixel_q, line_q, frame_q, cur_field_q;

    always_comb begin
        cfg          = mode_q ? IlaceCfg : ProgCfg;
        v_total      = (mode_q && field_q) ? cfg.v_total1 : cfg.v_total0;
        half_line    = cfg.h_total >> 1;
        h_last       = (h_q == cfg.h_total - HOne);
        frame_end    = h_last && (v_q == v_total - VOne);
        active       = (h_q < cfg.h_active) && (v_q < cfg.v_active);
        h_sync_start = cfg.h_active + cfg.h_fp;
        v_sync_start = cfg.v_active + cfg.v_fp;
        // Odd interlaced fields count sync lines from mid-line, shifting vsync by half a line.
        v_sync_cnt   = (mode_q && field_q && (h_q < half_line)) ? v_q - VOne : v_q;

        h_d     = h_q + HOne;
        v_d     = v_q;
        mode_d  = mode_q;
        field_d = field_q;
        if (frame_end) begin
            h_d     = '0;
            v_d     = '0;
            mode_d  = interlaced;
            field_d = interlaced && mode_q && !field_q;
        end else if (h_last) begin
            h_d = '0;
            v_d = v_q + VOne;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_q      <= 1'b0;
            h_q         <= '0;
            v_q         <= '0;
            mode_q      <= 1'b0;
            field_q     <= 1'b0;
            pixel_q     <= 1'b0;
            line_q      <= 1'b0;
            frame_q     <= 1'b0;
            cur_field_q <= 1'b0;
        end else begin
            tick_q <= ~tick_q;
            if (tick_q) begin
                h_q         <= h_d;
                v_q         <= v_d;
                mode_q      <= mode_d;
                field_q     <= field_d;
                pixel_q     <= active;
                line_q      <= h_last;
                frame_q     <= frame_end;
                cur_field_q <= mode_q & field_q;
            end
        end
    end

    sync_window #(.Width(HCntW)) u_hsync (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (tick_q),
        .cnt    (h_q),
        .start  (h_sync_start),
        .len    (cfg.h_sync),
        .sync_n (hsync_n)
    );

    sync_window #(.Width(VCntW)) u_vsync (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (tick_q),
        .cnt    (v_sync_cnt),
        .start  (v_sync_start),
        .len    (cfg.v_sync),
        .sync_n (vsync_n)
    );

    assign next_pixel    = pixel_q;
    assign blank         = ~pixel_q;
    assign next_line     = line_q;
    assign next_frame    = frame_q;
    assign current_field = cur_field_q;

endmodule

// File: tb/tb_video_timing.sv
// Bench for video_timing: full-size instance for horizontal timing, scaled instance for
// frame/field/mode behaviour against a position-based reference model.
module tb_video_timing;
    import video_timing_pkg::*;

    localparam timing_t SP = '{
        h_active: 11'd8,  h_fp: 11'd2, h_sync: 11'd3, h_total: 11'd16,
        v_active: 10'd5,  v_fp: 10'd2, v_sync: 10'd2, v_total0: 10'd11, v_total1: 10'd11
    };
    localparam timing_t SI = '{
        h_active: 11'd12, h_fp: 11'd2, h_sync: 11'd4, h_total: 11'd20,
        v_active: 10'd4,  v_fp: 10'd1, v_sync: 10'd2, v_total0: 10'd8,  v_total1: 10'd9
    };
    // {pix, blank, line, frame, hs_n, vs_n, field}
    localparam int RstOuts = 7'b0100110;

    typedef struct { int idx; int pix; int line; int hs; } vec_t;
    typedef struct { bit pix; bit line; bit frame; bit hs; bit vs; bit fld; } exp_t;

    logic clk = 1'b0;
    logic rst_n, il_f, il_s;
    logic f_pixel, f_line, f_frame, f_field, f_hs, f_vs, f_blank;
    logic s_pixel, s_line, s_frame, s_field, s_hs, s_vs, s_blank;

    int   n_checks = 0;
    int   n_fail = 0;
    int   tick_no, m_p;
    bit   m_mode, m_field;
    int   f_pix_cnt, f_hs_cnt, f_hs_first;
    vec_t tbl[12];

    always #5 clk = ~clk;

    video_timing dut_full (
        .clk(clk), .rst_n(rst_n), .interlaced(il_f), .next_pixel(f_pixel), .next_line(f_line),
        .next_frame(f_frame), .current_field(f_field), .hsync_n(f_hs), .vsync_n(f_vs),
        .blank(f_blank)
    );

    video_timing #(.ProgCfg(SP), .IlaceCfg(SI)) dut_small (
        .clk(clk), .rst_n(rst_n), .interlaced(il_s), .next_pixel(s_pixel), .next_line(s_line),
        .next_frame(s_frame), .current_field(s_field), .hsync_n(s_hs), .vsync_n(s_vs),
        .blank(s_blank)
    );

    function automatic int s_outs();
        return int'({s_pixel, s_blank, s_line, s_frame, s_hs, s_vs, s_field});
    endfunction

    function automatic int f_outs();
        return int'({f_pixel, f_blank, f_line, f_frame, f_hs, f_vs, f_field});
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a linear position within the current field plus mode/field.
    function automatic int m_ht();
        return m_mode ? int'(SI.h_total) : int'(SP.h_total);
    endfunction

    function automatic int m_vt();
        if (!m_mode) return int'(SP.v_total0);
        return m_field ? int'(SI.v_total1) : int'(SI.v_total0);
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        int   ht, ha, hf, hs, va, vf, vs, h, v, q;
        ht = m_ht();
        ha = m_mode ? int'(SI.h_active) : int'(SP.h_active);
        hf = m_mode ? int'(SI.h_fp)     : int'(SP.h_fp);
        hs = m_mode ? int'(SI.h_sync)   : int'(SP.h_sync);
        va = m_mode ? int'(SI.v_active) : int'(SP.v_active);
        vf = m_mode ? int'(SI.v_fp)     : int'(SP.v_fp);
        vs = m_mode ? int'(SI.v_sync)   : int'(SP.v_sync);
        h = m_p % ht;
        v = m_p / ht;
        q = (m_mode && m_field) ? m_p - ht / 2 : m_p;
        e.pix   = (h < ha) && (v < va);
        e.line  = (h == ht - 1);
        e.frame = (m_p == ht * m_vt() - 1);
        e.hs    = !((h >= ha + hf) && (h < ha + hf + hs));
        e.vs    = !((q >= (va + vf) * ht) && (q < (va + vf + vs) * ht));
        e.fld   = m_field;
        return e;
    endfunction

    function automatic void advance(input bit il);
        if (m_p == m_ht() * m_vt() - 1) begin
            m_field = il && m_mode && !m_field;
            m_mode  = il;
            m_p     = 0;
        end else begin
            m_p++;
        end
    endfunction

    task automatic model_reset();
        m_p = 0; m_mode = 1'b0; m_field = 1'b0; tick_no = 0;
    endtask

    // One tick: a non-tick edge (outputs must hold) then a tick edge (outputs update).
    task automatic step();
        exp_t e;
        bit   il;
        int   s_prev, f_prev, ev;
        e = model_out();
        il = il_s;
        s_prev = s_outs();
        f_prev = f_outs();
        @(posedge clk); #1;
        check("hold.small", s_outs(), s_prev);
        check("hold.full", f_outs(), f_prev);
        @(posedge clk); #1;
        check($sformatf("small.outs@p%0d", m_p), s_outs(),
              int'({e.pix, !e.pix, e.line, e.frame, e.hs, e.vs, e.fld}));
        if (tick_no == 0) begin
            f_pix_cnt = 0; f_hs_cnt = 0; f_hs_first = -1;
        end
        foreach (tbl[i]) begin
            if (tbl[i].idx == tick_no) begin
                ev = (tbl[i].pix << 5) | ((1 - tbl[i].pix) << 4) | (tbl[i].line << 3) |
                     (tbl[i].hs << 2) | 2;
                check($sformatf("full.vec@%0d", tick_no),
                      int'({f_pixel, f_blank, f_line, f_hs, f_vs, f_frame}), ev);
            end
        end
        if (tick_no < 800) begin
            f_pix_cnt += int'(f_pixel);
            if (!f_hs) begin
                if (f_hs_first < 0) f_hs_first = tick_no;
                f_hs_cnt++;
            end
        end
        if (tick_no == 799) begin
            check("full.pixels_per_line", f_pix_cnt, 640);
            check("full.hsync_width", f_hs_cnt, 96);
            check("full.hsync_start", f_hs_first, 656);
        end
        advance(il);
        tick_no++;
    endtask

    task automatic measure_field(input string tag, input int exp_len, input int exp_fall,
                                 input int exp_fld);
        int cnt, fall, fld;
        bit prev_vs, done;
        cnt = 0; fall = -1; fld = -1; prev_vs = s_vs; done = 1'b0;
        while (!done && cnt < 500) begin
            step();
            cnt++;
            if (cnt == 1) fld = int'(s_field);
            if (prev_vs && !s_vs && fall < 0) fall = cnt;
            prev_vs = s_vs;
            if (s_frame) done = 1'b1;
        end
        check({tag, ".len"}, cnt, exp_len);
        check({tag, ".vsync_fall"}, fall, exp_fall);
        check({tag, ".field"}, fld, exp_fld);
    endtask

    initial begin
        int cnt;
        tbl[0]  = '{0,    1, 0, 1};
        tbl[1]  = '{639,  1, 0, 1};
        tbl[2]  = '{640,  0, 0, 1};
        tbl[3]  = '{655,  0, 0, 1};
        tbl[4]  = '{656,  0, 0, 0};
        tbl[5]  = '{751,  0, 0, 0};
        tbl[6]  = '{752,  0, 0, 1};
        tbl[7]  = '{799,  0, 1, 1};
        tbl[8]  = '{800,  1, 0, 1};
        tbl[9]  = '{1439, 1, 0, 1};
        tbl[10] = '{1456, 0, 0, 0};
        tbl[11] = '{1599, 0, 1, 1};

        rst_n = 1'b0; il_f = 1'b0; il_s = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset.small", s_outs(), RstOuts);
        check("reset.full", f_outs(), RstOuts);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // Progressive run: full instance reaches line 2, h 300.
        repeat (1900) step();

        // Asynchronous reset mid-line, held 3 clk, with an interlaced request pending.
        il_s = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midreset.async.small", s_outs(), RstOuts);
        check("midreset.async.full", f_outs(), RstOuts);
        repeat (3) @(posedge clk);
        #1;
        check("midreset.held.small", s_outs(), RstOuts);
        check("midreset.held.full", f_outs(), RstOuts);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        repeat (10) step();
        il_s = 1'b0;

        // Mid-frame mode request: progressive timing runs to frame end.
        cnt = 0;
        while (m_p != 2 * int'(SP.h_total) && cnt < 400) begin
            step();
            cnt++;
        end
        check("switch.reached_line2", m_p, 2 * int'(SP.h_total));
        il_s = 1'b1;
        cnt = 0;
        while (cnt < 400) begin
            step();
            cnt++;
            if (s_frame) break;
        end
        check("switch.prog_remaining", cnt, 11 * 16 - 32);

        measure_field("ilace.f0a", 160, 101, 0);
        measure_field("ilace.f1",  180, 111, 1);
        measure_field("ilace.f0b", 160, 101, 0);

        // Random mode requests against the model.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 39) == 0) il_s = ~il_s;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
